// File: rtl/track_scroll_pipe.sv
// Two-stage pixel pipeline: maps screen pixels to a scrolled, upscaled
// background ROM address and returns the colour with matched sync delay.
module track_scroll_pipe #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_stb,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic              i_hs,
    input  logic              i_vs,
    input  logic              i_active,
    input  logic              i_frame_end,
    input  logic [3:0]        i_speed,
    input  logic              i_pause,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [11:0]       i_data,
    output logic              o_hs,
    output logic              o_vs,
    output logic [11:0]       o_rgb,
    output logic [6:0]        o_scroll
);

    logic [9:0]        col_d;
    logic [8:0]        row_d;
    logic [8:0]        row_src_d;
    logic [8:0]        scroll_ext;
    logic [7:0]        sum_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [6:0]        scroll_d;
    logic [6:0]        scroll_q;
    logic              active_q;
    logic              hs_q;
    logic              vs_q;
    logic [11:0]       rgb_q;
    logic              ohs_q;
    logic              ovs_q;

    always_comb begin
        col_d      = i_x >> SCALE_SHIFT;
        row_d      = i_y >> SCALE_SHIFT;
        scroll_ext = {2'b00, scroll_q};
        // Wrap the scrolled row back into the image with one compare/subtract
        if (row_d >= scroll_ext) begin
            row_src_d = row_d - scroll_ext;
        end else begin
            row_src_d = row_d + 9'(IMG_H) - scroll_ext;
        end
        addr_d = '0;
        if (i_active) begin
            addr_d = ADDR_W'(row_src_d) * ADDR_W'(IMG_W) + ADDR_W'(col_d);
        end
        sum_d    = {1'b0, scroll_q} + {4'b0000, i_speed};
        scroll_d = scroll_q;
        if (i_frame_end && !i_pause) begin
            if (sum_d >= 8'(IMG_H)) begin
                scroll_d = 7'(sum_d - 8'(IMG_H));
            end else begin
                scroll_d = 7'(sum_d);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q   <= '0;
            scroll_q <= '0;
            active_q <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            rgb_q    <= '0;
            ohs_q    <= 1'b1;
            ovs_q    <= 1'b1;
        end else if (i_pix_stb) begin
            addr_q   <= addr_d;
            scroll_q <= scroll_d;
            active_q <= i_active;
            hs_q     <= i_hs;
            vs_q     <= i_vs;
            rgb_q    <= active_q ? i_data : 12'h000;
            ohs_q    <= hs_q;
            ovs_q    <= vs_q;
        end
    end

    assign o_addr   = addr_q;
    assign o_scroll = scroll_q;
    assign o_rgb    = rgb_q;
    assign o_hs     = ohs_q;
    assign o_vs     = ovs_q;

endmodule

// File: tb/tb_track_scroll_pipe.sv
// Bench for track_scroll_pipe: directed vectors, a frame-level reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_track_scroll_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        hs, vs, act, fe, pause;
    logic [3:0]  speed;
    logic [14:0] addr;
    logic [11:0] data;
    logic        ohs, ovs;
    logic [11:0] rgb;
    logic [6:0]  scroll;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // reference model state: what each output must currently show
    int m_addr, m_rgb, m_hs, m_vs, m_scroll;
    int p_act, p_hs, p_vs;

    always #5 clk = ~clk;

    track_scroll_pipe dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
        .i_x(x), .i_y(y), .i_hs(hs), .i_vs(vs),
        .i_active(act), .i_frame_end(fe), .i_speed(speed),
        .i_pause(pause), .o_addr(addr), .i_data(data),
        .o_hs(ohs), .o_vs(ovs), .o_rgb(rgb), .o_scroll(scroll)
    );

    function automatic logic [11:0] rom(input logic [14:0] a);
        return a[11:0] ^ 12'hA5A;
    endfunction

    // synchronous ROM: data valid one clock after the address
    always @(posedge clk) data <= rom(addr);

    task automatic cmp(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("addr", int'(addr), m_addr);
            cmp("rgb", int'(rgb), m_rgb);
            cmp("hs", int'(ohs), m_hs);
            cmp("vs", int'(ovs), m_vs);
            cmp("scroll", int'(scroll), m_scroll);
        end
    end

    task automatic model_step(input logic r, input logic s);
        int row;
        if (r) begin
            m_addr = 0; m_rgb = 0; m_hs = 1; m_vs = 1; m_scroll = 0;
            p_act = 0; p_hs = 1; p_vs = 1;
        end else if (s) begin
            m_rgb = (p_act != 0) ? int'(rom(15'(m_addr))) : 0;
            m_hs  = p_hs;
            m_vs  = p_vs;
            row   = int'(y) / 4;
            m_addr = act ? ((row + 120 - m_scroll) % 120) * 160 + int'(x) / 4 : 0;
            p_act = int'(act); p_hs = int'(hs); p_vs = int'(vs);
            if (fe && !pause) m_scroll = (m_scroll + int'(speed)) % 120;
        end
    endtask

    task automatic tick(input logic s);
        logic r_s;
        stb = s;
        r_s = rst;
        @(posedge clk);
        #1;
        model_step(r_s, s);
    endtask

    task automatic strobe();
        tick(1'b1);
        repeat (3) tick(1'b0);
    endtask

    task automatic pix(input int px, input int py);
        x = 10'(px);
        y = 9'(py);
        strobe();
    endtask

    task automatic frame_end(input int spd);
        fe = 1'b1;
        speed = 4'(spd);
        strobe();
        fe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; x = '0; y = '0;
        hs = 1'b1; vs = 1'b1; act = 1'b1; fe = 1'b0;
        speed = '0; pause = 1'b0;
        tick(1'b0);
        tick(1'b1);
        chk_en = 1;
        cmp("rst_addr", int'(addr), 0);
        cmp("rst_rgb", int'(rgb), 0);
        cmp("rst_hs", int'(ohs), 1);
        cmp("rst_vs", int'(ovs), 1);
        cmp("rst_scroll", int'(scroll), 0);
        rst = 1'b0;

        pix(0, 0);
        cmp("addr_origin", int'(addr), 0);
        pix(639, 479);
        cmp("addr_corner", int'(addr), 19199);
        hs = 1'b0;
        pix(320, 32);
        hs = 1'b1;
        cmp("addr_1360", int'(addr), 1360);
        cmp("rgb_corner", int'(rgb), 12'h0A5);
        cmp("hs_not_yet", int'(ohs), 1);
        pix(0, 0);
        cmp("rgb_F0A", int'(rgb), 12'hF0A);
        cmp("hs_pulse", int'(ohs), 0);
        pix(4, 0);
        cmp("hs_back", int'(ohs), 1);

        act = 1'b0;
        pix(100, 100);
        cmp("blank_addr", int'(addr), 0);
        pix(200, 200);
        cmp("blank_rgb", int'(rgb), 0);
        act = 1'b1;

        frame_end(5);
        cmp("scroll_5", int'(scroll), 5);
        pix(0, 0);
        cmp("addr_scroll_top", int'(addr), 18400);
        pix(0, 20);
        cmp("addr_scroll_row5", int'(addr), 0);

        // inputs churn with the strobe low: nothing may move
        x = 10'd600; y = 9'd300; hs = 1'b0; vs = 1'b0;
        act = 1'b0; fe = 1'b1; speed = 4'd9;
        repeat (3) tick(1'b0);
        cmp("gate_scroll", int'(scroll), 5);
        cmp("gate_addr", int'(addr), 0);
        cmp("gate_hs", int'(ohs), 1);
        fe = 1'b0; hs = 1'b1; vs = 1'b1; act = 1'b1;

        repeat (7) frame_end(15);
        cmp("scroll_110", int'(scroll), 110);
        frame_end(8);
        cmp("scroll_118", int'(scroll), 118);
        pix(8, 0);
        cmp("addr_s118", int'(addr), 2*160 + 2);
        frame_end(7);
        cmp("wrap_118_7", int'(scroll), 5);
        repeat (7) frame_end(15);
        frame_end(15);
        cmp("wrap_110_15", int'(scroll), 5);
        pause = 1'b1;
        frame_end(9);
        cmp("pause_hold", int'(scroll), 5);
        pause = 1'b0;
        frame_end(0);
        cmp("speed0_hold", int'(scroll), 5);

        // speed changed mid-frame is only taken at frame end
        speed = 4'd12;
        pix(40, 40);
        cmp("speed_midframe", int'(scroll), 5);

        frame_end(15);
        frame_end(15);
        frame_end(5);
        cmp("scroll_40", int'(scroll), 40);
        hs = 1'b0; vs = 1'b0;
        pix(123, 77);
        pix(124, 78);
        rst = 1'b1;
        tick(1'b0);
        cmp("midrst_scroll", int'(scroll), 0);
        cmp("midrst_rgb", int'(rgb), 0);
        cmp("midrst_hs", int'(ohs), 1);
        cmp("midrst_vs", int'(ovs), 1);
        rst = 1'b0;
        hs = 1'b1; vs = 1'b1;
        pix(0, 8);
        cmp("resume_addr", int'(addr), 320);
        frame_end(3);
        cmp("resume_scroll", int'(scroll), 3);
        pix(12, 0);
        cmp("resume_addr_s3", int'(addr), 117*160 + 3);
        for (int i = 0; i < 6; i++) pix(i * 97, i * 61);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
